// File: rtl/fifo_pkg.sv
// Shared FIFO types and sizing helpers, used by sync_fifo and the dual-clock FIFO.
package fifo_pkg;

  // Status flags common to all FIFO flavours
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic oflow;
    logic uflow;
  } fifo_status_t;

  localparam int unsigned FIFO_AE_DEFAULT = 32'd2;

  // Number of entries addressed by a pointer of the given width
  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'd1 << ptr_width;
  endfunction

  // Default almost-full threshold: two entries below full
  function automatic int unsigned fifo_af_default(input int unsigned ptr_width);
    return fifo_depth(ptr_width) - 32'd2;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for sync_fifo.
// SYNC_FIFO_FWFT_EN: asynchronous read port; otherwise a registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic                  rst_n,
  input  logic                  rd_en,
`endif
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible as soon as it is written
  assign rd_data = mem[rd_addr];
`else
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Registered read port, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// synchronous flush and overflow/underflow pulses.
// SYNC_FIFO_FWFT_EN: first-word-fall-through read mode; otherwise one-cycle read latency.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 4,
  parameter int unsigned AF_THRESH  = fifo_af_default(PTR_WIDTH),
  parameter int unsigned AE_THRESH  = FIFO_AE_DEFAULT
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  oflow,
  output logic                  uflow
);

  localparam int unsigned CW    = PTR_WIDTH + 1;
  localparam int unsigned DEPTH = fifo_depth(PTR_WIDTH);

  logic [CW-1:0]         wr_ptr_q;
  logic [CW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  fifo_status_t          status_q;
  fifo_status_t          status_nxt;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Accepted transfers use the registered flags; flush suppresses both
  always_comb begin
    wr_acc_c = wr_en && !status_q.full  && !clr;
    rd_acc_c = rd_en && !status_q.empty && !clr;
  end

  // Next occupancy and flags, so registered flags carry no extra lag
  always_comb begin
    count_nxt = count_q;
    if (clr) begin
      count_nxt = '0;
    end else begin
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_nxt = count_q + CW'(1);
        2'b01:   count_nxt = count_q - CW'(1);
        default: count_nxt = count_q;
      endcase
    end
    status_nxt.full         = (count_nxt == CW'(DEPTH));
    status_nxt.empty        = (count_nxt == '0);
    status_nxt.almost_full  = (count_nxt >= CW'(AF_THRESH));
    status_nxt.almost_empty = (count_nxt <= CW'(AE_THRESH));
    status_nxt.oflow        = !clr && wr_en && status_q.full;
    status_nxt.uflow        = !clr && rd_en && status_q.empty;
  end

  // Pointer, count and flag registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                    almost_empty: 1'b1, oflow: 1'b0, uflow: 1'b0};
    end else begin
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_acc_c) wr_ptr_q <= wr_ptr_q + CW'(1);
        if (rd_acc_c) rd_ptr_q <= rd_ptr_q + CW'(1);
      end
      count_q  <= count_nxt;
      status_q <= status_nxt;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk     (aclk),
`ifndef SYNC_FIFO_FWFT_EN
    .rst_n   (aresetn),
    .rd_en   (rd_acc_c),
`endif
    .wr_en   (wr_acc_c),
    .wr_addr (wr_ptr_q[PTR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[PTR_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word shown while non-empty; zero otherwise so reset reads back 0
  assign rd_data  = status_q.empty ? '0 : mem_rd_data;
  assign rd_valid = !status_q.empty;
`else
  logic rd_valid_q;

  // Valid follows each accepted read by one cycle
  always_ff @(posedge aclk) begin
    if (!aresetn) rd_valid_q <= 1'b0;
    else          rd_valid_q <= rd_acc_c;
  end

  assign rd_data  = mem_rd_data;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign oflow        = status_q.oflow;
  assign uflow        = status_q.uflow;
  assign count        = count_q;

endmodule
